// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT peak-detect stage.
package fft_pkg;
    localparam int N_DEF     = 256;
    localparam int W_DEF     = 32;
    localparam int BIN_W_DEF = $clog2(N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_REPORT
    } state_t;
endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage |X|^2 = re^2 + im^2 with valid and bin index carried beside the data.
module mag_sq_pipe #(
    parameter int W     = 32,
    parameter int BIN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_p0,
    input  logic signed [W-1:0]  re_p0,
    input  logic signed [W-1:0]  im_p0,
    input  logic [BIN_W-1:0]     bin_p0,
    output logic                 vld_p2,
    output logic [2*W-1:0]       mag_p2,
    output logic [BIN_W-1:0]     bin_p2
);
    logic                  vld_p1;
    logic signed [2*W-1:0] re_sq_p1;
    logic signed [2*W-1:0] im_sq_p1;
    logic [BIN_W-1:0]      bin_p1;

    function automatic logic signed [2*W-1:0] square(input logic signed [W-1:0] x);
        logic signed [2*W-1:0] xe;
        xe = {{W{x[W-1]}}, x};
        return xe * xe;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // S1: squares; S2: sum, which tops out at 2^(2W-1) and so fits unsigned 2W
    always_ff @(posedge clk) begin
        re_sq_p1 <= square(re_p0);
        im_sq_p1 <= square(im_p0);
        bin_p1   <= bin_p0;
        mag_p2   <= $unsigned(re_sq_p1) + $unsigned(im_sq_p1);
        bin_p2   <= bin_p1;
    end
endmodule

// File: rtl/fft_peak_detect.sv
// Finds the strongest bin of the non-redundant half-spectrum of each FFT frame.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int SKIP_DC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [W-1:0]    in_re,
    input  logic signed [W-1:0]    in_im,
    output logic                   peak_valid,
    output logic [$clog2(N)-1:0]   peak_bin,
    output logic [2*W-1:0]         peak_mag,
    output logic [7:0]             frame_cnt,
    output logic                   busy
);
    localparam int BW = $clog2(N);

    state_t         state;
    logic [BW-1:0]  bin_cnt;
    logic           drain_cnt;
    logic [2*W-1:0] best_mag;
    logic [BW-1:0]  best_bin;
    logic           best_set;
    logic           accept;
    logic           vld_p2;
    logic [2*W-1:0] mag_p2;
    logic [BW-1:0]  bin_p2;
    logic           cand_p2;

    assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
    assign accept   = in_valid && in_ready;

    mag_sq_pipe #(.W(W), .BIN_W(BW)) u_mag (
        .clk    (clk),
        .rst    (rst),
        .vld_p0 (accept),
        .re_p0  (in_re),
        .im_p0  (in_im),
        .bin_p0 (bin_cnt),
        .vld_p2 (vld_p2),
        .mag_p2 (mag_p2),
        .bin_p2 (bin_p2)
    );

    // Upper half (MSB set) mirrors the lower half for real input, so it is never searched
    assign cand_p2 = !bin_p2[BW-1] && !((SKIP_DC != 0) && (bin_p2 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bin_cnt    <= '0;
            drain_cnt  <= 1'b0;
            best_mag   <= '0;
            best_bin   <= '0;
            best_set   <= 1'b0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            // Compare stage: strict > keeps the lower index on ties
            if (vld_p2 && cand_p2 && (!best_set || mag_p2 > best_mag)) begin
                best_mag <= mag_p2;
                best_bin <= bin_p2;
                best_set <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bin_cnt  <= BW'(1);
                        best_mag <= '0;
                        best_bin <= '0;
                        best_set <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        bin_cnt <= bin_cnt + BW'(1);
                        if (bin_cnt == BW'(N - 1)) begin
                            drain_cnt <= 1'b0;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) state <= ST_REPORT;
                    else           drain_cnt <= 1'b1;
                end
                ST_REPORT: begin
                    peak_bin   <= best_bin;
                    peak_mag   <= best_mag;
                    peak_valid <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed and randomized frames checked against a loop-based peak-search model.
module tb_fft_peak_detect;
    localparam int N = 256;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, in_valid;
    logic signed [W-1:0] in_re, in_im;
    logic                in_ready, peak_valid, busy;
    logic [7:0]          peak_bin, frame_cnt;
    logic [63:0]         peak_mag;
    logic                in_ready0, peak_valid0, busy0;
    logic [7:0]          peak_bin0, frame_cnt0;
    logic [63:0]         peak_mag0;

    fft_peak_detect #(.N(N), .W(W), .SKIP_DC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .peak_valid(peak_valid), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .frame_cnt(frame_cnt), .busy(busy)
    );

    fft_peak_detect #(.N(N), .W(W), .SKIP_DC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_re(in_re), .in_im(in_im), .peak_valid(peak_valid0), .peak_bin(peak_bin0),
        .peak_mag(peak_mag0), .frame_cnt(frame_cnt0), .busy(busy0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int exp_fc = 0;
    longint fre[N];
    longint fim[N];

    int          pk_bin_q[$];
    logic [63:0] pk_mag_q[$];
    int          pk_cyc_q[$];
    int          pk0_bin_q[$];
    logic [63:0] pk0_mag_q[$];
    int          low_q[$];
    int          low_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (peak_valid === 1'b1) begin
            pk_bin_q.push_back(int'(peak_bin));
            pk_mag_q.push_back(peak_mag);
            pk_cyc_q.push_back(cyc);
        end
        if (peak_valid0 === 1'b1) begin
            pk0_bin_q.push_back(int'(peak_bin0));
            pk0_mag_q.push_back(peak_mag0);
        end
        if (in_ready === 1'b0) low_run++;
        else if (low_run > 0) begin
            low_q.push_back(low_run);
            low_run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: scan the searchable bins, replace only on strictly larger magnitude
    task automatic model(input int skip, output int bb, output logic [63:0] bm);
        bit          set;
        logic [63:0] m;
        set = 0; bb = 0; bm = 0;
        for (int k = (skip != 0 ? 1 : 0); k < N / 2; k++) begin
            m = 64'(fre[k] * fre[k]) + 64'(fim[k] * fim[k]);
            if (!set || m > bm) begin
                set = 1; bb = k; bm = m;
            end
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < N; k++) begin
            fre[k] = 0; fim[k] = 0;
        end
    endtask

    task automatic clear_q();
        pk_bin_q.delete(); pk_mag_q.delete(); pk_cyc_q.delete();
        pk0_bin_q.delete(); pk0_mag_q.delete(); low_q.delete();
    endtask

    task automatic send_beats(input int first, input int cnt, input int gap_pct);
        for (int k = first; k < first + cnt; k++) begin
            bit done;
            int tries;
            done = 0; tries = 0;
            while (!done) begin
                if ($urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0; in_re = $urandom; in_im = $urandom;
                end else begin
                    in_valid = 1'b1; in_re = fre[k][31:0]; in_im = fim[k][31:0];
                end
                done = in_valid && in_ready;
                if (done) last_acc = cyc + 1;
                @(posedge clk); #1;
                tries++;
                if (tries > 1000) begin
                    $display("FAIL send_beats: bin %0d never accepted", k);
                    $fatal(1, "stalled");
                end
            end
        end
    endtask

    task automatic wait_peaks(input int n, input string tag);
        int t;
        t = 0;
        while (pk_bin_q.size() < n && t < 60) begin
            @(posedge clk); #1; t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_pulses"}, pk_bin_q.size(), n);
    endtask

    task automatic check_frame(input string tag);
        int b1, b0;
        logic [63:0] m1, m0;
        model(1, b1, m1);
        model(0, b0, m0);
        wait_peaks(1, tag);
        exp_fc++;
        if (pk_bin_q.size() > 0) begin
            check({tag, "_bin"}, pk_bin_q[0], b1);
            check({tag, "_mag"}, pk_mag_q[0], m1);
            check({tag, "_latency"}, pk_cyc_q[0], last_acc + 3);
        end
        check({tag, "_bin_dc"}, pk0_bin_q.size() > 0 ? pk0_bin_q[0] : -1, b0);
        check({tag, "_mag_dc"}, pk0_mag_q.size() > 0 ? pk0_mag_q[0] : '1, m0);
        check({tag, "_frame_cnt"}, frame_cnt, exp_fc);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fc = 0;
    endtask

    initial begin
        int eb[5];
        logic [63:0] em[5];
        int dummy;
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        clear_frame(); clear_q();
        fre[10] = 3; fim[10] = 4;
        send_beats(0, 1, 0);
        check("f1_busy_mid", busy, 1);
        send_beats(1, N - 1, 0);
        in_valid = 1'b0;
        check_frame("f1");
        check("f1_bin_const", peak_bin, 10);
        check("f1_mag_const", peak_mag, 25);

        clear_frame(); clear_q();
        fre[0] = 1000; fre[5] = 10;
        send_beats(0, N, 0); in_valid = 1'b0;
        check_frame("f2");
        check("f2_dc_mag_const", peak_mag0, 1000000);

        clear_frame(); clear_q();
        fre[7] = -6; fim[7] = 8; fre[20] = -6; fim[20] = 8; fre[200] = 100; fim[200] = 100;
        send_beats(0, N, 0); in_valid = 1'b0;
        check_frame("f3");
        check("f3_bin_const", peak_bin, 7);

        clear_frame(); clear_q();
        fre[3] = -64'sd2147483648; fim[3] = -64'sd2147483648;
        send_beats(0, N, 50); in_valid = 1'b0;
        check_frame("f4");
        check("f4_mag_const", peak_mag, 64'h8000_0000_0000_0000);

        for (int k = 0; k < N; k++) begin
            fre[k] = longint'($signed($urandom)); fim[k] = longint'($signed($urandom));
        end
        clear_q();
        send_beats(0, 100, 0);
        do_reset();
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        clear_frame();
        fim[50] = 9;
        send_beats(0, N, 0); in_valid = 1'b0;
        check_frame("f5");
        check("f5_bin_const", peak_bin, 50);
        check("f5_mag_const", peak_mag, 81);

        for (int f = 0; f < 3; f++) begin
            clear_q();
            for (int k = 0; k < N; k++) begin
                if (f < 2) begin
                    fre[k] = longint'($urandom_range(15)) - 8;
                    fim[k] = longint'($urandom_range(15)) - 8;
                end else begin
                    fre[k] = longint'($signed($urandom));
                    fim[k] = longint'($signed($urandom));
                end
            end
            send_beats(0, N, 30); in_valid = 1'b0;
            check_frame($sformatf("rnd%0d", f));
        end

        do_reset();
        clear_q();
        for (int f = 0; f < 5; f++) begin
            clear_frame(); fre[f + 1] = 5;
            model(1, eb[f], em[f]);
        end
        for (int f = 0; f < 5; f++) begin
            clear_frame(); fre[f + 1] = 5;
            send_beats(0, N, 0);
        end
        in_valid = 1'b0;
        wait_peaks(5, "b2b");
        for (int f = 0; f < 5; f++) begin
            dummy = pk_bin_q.size() > f ? pk_bin_q[f] : -1;
            check($sformatf("b2b%0d_bin", f), dummy, eb[f]);
            check($sformatf("b2b%0d_mag", f), pk_mag_q.size() > f ? pk_mag_q[f] : '1, em[f]);
        end
        check("b2b_frame_cnt", frame_cnt, 5);
        check("b2b_low_runs", low_q.size(), 5);
        for (int f = 0; f < low_q.size(); f++)
            check($sformatf("b2b_low_len%0d", f), low_q[f], 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
